// File: rtl/port_uart_tx.sv
// UART transmitter behind a CPU port pair: toggle-handshake command word in, status word out.
// Define PORT_UART_TX_PARITY_EN to insert an even-parity bit after the eighth data bit.
module port_uart_tx #(
    parameter int CLOCKS_PER_BIT = 434,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] commandWord,
    output logic [31:0] statusWord,
    output logic        txd
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLOCKS_PER_BIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef PORT_UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t             state, state_next;
    logic [BAUD_W-1:0]  baud_cnt, baud_next;
    logic [2:0]         bit_cnt, bit_next;
    logic [7:0]         shift_reg, shift_next;
    logic               txd_next;
`ifdef PORT_UART_TX_PARITY_EN
    logic               parity, parity_next;
`endif

    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [7:0]         head;

    logic               prev_toggle;
    logic               ack_toggle;
    logic               overflow;
    logic               send, full, pop, push, drop, busy, baud_done;

    logic               unused_cmd;
    assign unused_cmd = ^commandWord[30:9];

    // A push into a full FIFO is still legal when the FSM frees a slot on the same edge.
    assign send      = commandWord[8] ^ prev_toggle;
    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign pop       = (state == S_IDLE) && (count != '0);
    assign push      = send && (!full || pop);
    assign drop      = send && full && !pop;
    assign head      = fifo_mem[rd_ptr];
    assign busy      = (state != S_IDLE) || (count != '0);
    assign baud_done = (baud_cnt == BAUD_W'(CLOCKS_PER_BIT - 1));

    // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latches).
    always_comb begin
        state_next  = state;
        baud_next   = baud_cnt + BAUD_W'(1);
        bit_next    = bit_cnt;
        shift_next  = shift_reg;
`ifdef PORT_UART_TX_PARITY_EN
        parity_next = parity;
`endif
        case (state)
            S_IDLE: begin
                baud_next = '0;
                if (pop) begin
                    state_next = S_START;
                    shift_next = head;
                    bit_next   = '0;
`ifdef PORT_UART_TX_PARITY_EN
                    parity_next = ^head;
`endif
                end
            end
            S_START: begin
                if (baud_done) begin
                    state_next = S_DATA;
                    baud_next  = '0;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_next = '0;
                    if (bit_cnt == 3'd7) begin
`ifdef PORT_UART_TX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end else begin
                        shift_next = {1'b0, shift_reg[7:1]};
                        bit_next   = bit_cnt + 3'd1;
                    end
                end
            end
`ifdef PORT_UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_done) begin
                    state_next = S_STOP;
                    baud_next  = '0;
                end
            end
`endif
            S_STOP: begin
                if (baud_done) begin
                    state_next = S_IDLE;
                    baud_next  = '0;
                end
            end
            default: begin
                state_next = S_IDLE;
                baud_next  = '0;
            end
        endcase

        // txd is decoded from the next state so the line itself comes straight from a flop.
        case (state_next)
            S_START:  txd_next = 1'b0;
            S_DATA:   txd_next = shift_next[0];
`ifdef PORT_UART_TX_PARITY_EN
            S_PARITY: txd_next = parity_next;
`endif
            default:  txd_next = 1'b1;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            txd         <= 1'b1;
`ifdef PORT_UART_TX_PARITY_EN
            parity      <= 1'b0;
`endif
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            prev_toggle <= 1'b0;
            ack_toggle  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_next;
            baud_cnt    <= baud_next;
            bit_cnt     <= bit_next;
            shift_reg   <= shift_next;
            txd         <= txd_next;
`ifdef PORT_UART_TX_PARITY_EN
            parity      <= parity_next;
`endif
            prev_toggle <= commandWord[8];
            if (push) begin
                wr_ptr     <= wr_ptr + PTR_W'(1);
                ack_toggle <= ~ack_toggle;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (commandWord[31]) begin
                overflow <= 1'b0;
            end
        end
    end

    // NOTE: the FIFO storage has no reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= commandWord[7:0];
        end
    end

    assign statusWord = {16'h0000, 8'(count), 4'h0, overflow, ack_toggle, full, busy};

endmodule

// File: tb/tb_port_uart_tx.sv
// Bench for port_uart_tx: status vectors, exact txd timing, and a serial-decoding scoreboard.
module tb_port_uart_tx;
    localparam int CPB = 4;
    localparam int DEPTH = 4;
`ifdef PORT_UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CLK = FRAME_BITS * CPB;

    logic        clock;
    logic        reset;
    logic [31:0] commandWord;
    logic [31:0] statusWord;
    logic        txd;

    port_uart_tx #(
        .CLOCKS_PER_BIT(CPB),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .commandWord(commandWord),
        .statusWord (statusWord),
        .txd        (txd)
    );

    typedef struct {
        logic [31:0] cmd;
        logic [31:0] exp_status;
    } vec_t;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  sb_q[$];
    logic        tog = 1'b0;

    logic        mon_active;
    int          mon_cnt;
    int          bit_idx;
    logic [7:0]  mon_byte;
    logic [7:0]  exp_b;
    logic        mon_par;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic logic exp_txd(input logic [7:0] d, input int k);
        int b;
        b = k / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef PORT_UART_TX_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // One send from idle/empty with overflow clear, then the whole frame checked clock by clock.
    task automatic frame_test(input logic [7:0] d);
        tog = ~tog;
        commandWord = {1'b0, 22'h0, tog, d};
        sb_q.push_back(d);
        tick(1);
        check("status after send", statusWord, 32'h0000_0101 | {29'h0, tog, 2'b00});
        check("txd before start", {31'h0, txd}, 32'h1);
        for (int k = 0; k < FRAME_CLK; k++) begin
            tick(1);
            check($sformatf("txd byte %02h clk %0d", d, k), {31'h0, txd}, {31'h0, exp_txd(d, k)});
            if (k == FRAME_CLK - 1)
                check("busy in last stop clk", statusWord, {29'h0, tog, 2'b01});
        end
        tick(1);
        check("idle after frame", statusWord, {29'h0, tog, 2'b00});
        check("txd after frame", {31'h0, txd}, 32'h1);
    endtask

    // Serial monitor: decodes each frame at bit midpoints and compares against the scoreboard.
    initial begin
        mon_active = 1'b0;
        mon_cnt = 0;
        mon_byte = '0;
        mon_par = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                mon_active = 1'b0;
            end else if (!mon_active) begin
                if (txd == 1'b0) begin
                    mon_active = 1'b1;
                    mon_cnt = 0;
                end
            end else begin
                mon_cnt++;
                if (mon_cnt % CPB == CPB / 2) begin
                    bit_idx = mon_cnt / CPB;
                    if (bit_idx == 0) check("start bit", {31'h0, txd}, 32'h0);
                    if (bit_idx >= 1 && bit_idx <= 8) mon_byte[bit_idx-1] = txd;
                    if (bit_idx == 9) mon_par = txd;
                    if (bit_idx == FRAME_BITS - 1) begin
                        check("stop bit", {31'h0, txd}, 32'h1);
                        if (sb_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected frame: actual %h, expected none", mon_byte);
                        end else begin
                            exp_b = sb_q.pop_front();
                            check("serial byte", {24'h0, mon_byte}, {24'h0, exp_b});
`ifdef PORT_UART_TX_PARITY_EN
                            check("parity bit", {31'h0, mon_par}, {31'h0, ^exp_b});
`endif
                        end
                        mon_active = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: actual timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        // Burst of six sends from idle; toggle was left at 1 by the previous frame.
        vecs[0] = '{32'h0000_0001, 32'h0000_0101};
        vecs[1] = '{32'h0000_0102, 32'h0000_0105};
        vecs[2] = '{32'h0000_0003, 32'h0000_0201};
        vecs[3] = '{32'h0000_0104, 32'h0000_0305};
        vecs[4] = '{32'h0000_0005, 32'h0000_0403};
        vecs[5] = '{32'h0000_0106, 32'h0000_040B};

        // Reset behaviour, including an abort in the middle of a data bit.
        reset = 1'b1;
        commandWord = 32'h0;
        tick(3);
        check("txd in reset", {31'h0, txd}, 32'h1);
        check("status in reset", statusWord, 32'h0);
        reset = 1'b0;
        tick(2);
        check("txd after reset", {31'h0, txd}, 32'h1);
        check("status after reset", statusWord, 32'h0);

        tog = 1'b1;
        commandWord = 32'h0000_0100;
        tick(10);
        check("txd mid data", {31'h0, txd}, 32'h0);
        #2;
        reset = 1'b1;
        commandWord = 32'h0;
        #1;
        check("txd async reset", {31'h0, txd}, 32'h1);
        check("status async reset", statusWord, 32'h0);
        tick(1);
        reset = 1'b0;
        tog = 1'b0;
        tick(2);

        // Single byte with exact frame timing.
        frame_test(8'h55);
        tick(2);

        // Burst fills the FIFO and overflows.
        for (int i = 1; i <= 5; i++) sb_q.push_back(8'(i));
        for (int i = 0; i < 6; i++) begin
            commandWord = vecs[i].cmd;
            tick(1);
            check($sformatf("burst vec %0d", i), statusWord, vecs[i].exp_status);
        end
        tog = 1'b1;

        // Overflow clear, then clear coinciding with a dropped send.
        commandWord = 32'h8000_0106;
        tick(1);
        check("overflow cleared", statusWord, 32'h0000_0403);
        tog = 1'b0;
        commandWord = 32'h8000_0007;
        tick(1);
        check("drop beats clear", statusWord, 32'h0000_040B);
        commandWord = 32'h0000_0007;

        // Send on the IDLE cycle where the full FIFO pops.
        tick(FRAME_CLK + 2 - 8);
        tog = 1'b1;
        commandWord = 32'h0000_01A5;
        sb_q.push_back(8'hA5);
        tick(1);
        check("push on pop when full", statusWord, 32'h0000_040F);

        for (int i = 0; i < 2000; i++) begin
            if (!statusWord[0] && sb_q.size() == 0) break;
            tick(1);
        end
        check("drained status", statusWord, 32'h0000_000C);
        commandWord = 32'h8000_01A5;
        tick(1);
        check("overflow clear idle", statusWord, 32'h0000_0004);
        commandWord = 32'h0000_01A5;
        tick(2);

        // Parity-sensitive bytes (odd and even popcount).
        frame_test(8'h07);
        tick(1);
        frame_test(8'h03);
        tick(4);
        check("scoreboard empty", sb_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
